// File: rtl/div_16.sv
//==============================================================================
// Module      : div_16
// Description : 16-bit unsigned restoring shift-subtract divider. A rising edge
//               on init_in captures A and B; one quotient bit is produced per
//               clock and the registered quotient appears on Result together
//               with a single-cycle done pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_in,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Result,
  output logic        done
);

  // Number of shift-subtract iterations, one per quotient bit
  localparam logic [4:0] c_ITERATIONS = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_init_d;     // init_in delayed by one clock, for edge detection
  logic [15:0] r_dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [15:0] r_divisor;
  logic [16:0] r_rem;        // partial remainder
  logic [4:0]  r_count;      // iterations still to perform

  logic        w_start;
  logic [16:0] w_rem_shift;
  logic        w_q_bit;
  logic [16:0] w_rem_next;

  // A start request is a 0->1 transition of init_in; only honoured in IDLE
  assign w_start = init_in & ~r_init_d;

  // Bring the next dividend bit into the remainder, then trial-subtract.
  // Bit 16 of the stored remainder can only be set when the divisor is zero,
  // in which case the quotient bit is 1 regardless, so OR-ing it in is exact.
  assign w_rem_shift = {r_rem[15:0], r_dividend[15]};
  assign w_q_bit     = r_rem[16] | (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_q_bit ? (w_rem_shift - {1'b0, r_divisor}) : w_rem_shift;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> CALC on start, CALC -> DONE after the last bit
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next_state = CALC;
        end
      end
      CALC: begin
        if (r_count == 5'd1) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Edge register keeps tracking init_in in every state so a level held
  // through completion cannot retrigger once the FSM is back in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_d <= 1'b0;
    end else begin
      r_init_d <= init_in;
    end
  end

  // Datapath: operand capture, iteration, and result/done registration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dividend <= 16'd0;
      r_divisor  <= 16'd0;
      r_rem      <= 17'd0;
      r_count    <= 5'd0;
      Result     <= 16'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_dividend <= A;
            r_divisor  <= B;
            r_rem      <= 17'd0;
            r_count    <= c_ITERATIONS;
          end
        end
        CALC: begin
          r_rem      <= w_rem_next;
          r_dividend <= {r_dividend[14:0], w_q_bit};
          r_count    <= r_count - 5'd1;
        end
        DONE: begin
          // After 16 iterations the dividend register holds the quotient
          Result <= r_dividend;
          done   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_16.sv
//==============================================================================
// Module      : tb_div_16
// Description : Self-checking bench for div_16 against an arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_16;

  logic        clk;
  logic        rst;
  logic        init_in;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Result;
  logic        done;

  int checks   = 0;
  int failures = 0;

  div_16 dut (
    .clk    (clk),
    .rst    (rst),
    .init_in(init_in),
    .A      (A),
    .B      (B),
    .Result (Result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor(a/b), all ones for a zero divisor
  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return 16'hFFFF;
    return a / b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Start one division and watch 41 cycles: latency, value, single pulse,
  // Result stability mid-calculation, optional disturbance of A/B/init_in.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int hold, input int disturb_at, input string name);
    logic [15:0] prev;
    logic [15:0] res;
    int          lat;
    int          pulses;
    @(negedge clk);
    A       = a;
    B       = b;
    init_in = 1'b1;
    prev    = Result;
    lat     = -1;
    pulses  = 0;
    res     = 16'd0;
    @(posedge clk);
    #1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = Result;
        end
      end
      if (k == 8) check({name, " result_held"}, {16'd0, Result}, {16'd0, prev});
      if (k == hold - 1) init_in = 1'b0;
      if (disturb_at > 0) begin
        if (k == disturb_at) begin
          A       = ~a;
          B       = b + 16'd3;
          init_in = 1'b0;
        end
        if (k == disturb_at + 1) init_in = 1'b1;
        if (k == disturb_at + 2) init_in = 1'b0;
      end
    end
    init_in = 1'b0;
    check({name, " latency"}, lat, 17);
    check({name, " result"}, {16'd0, res}, {16'd0, ref_div(a, b)});
    check({name, " pulses"}, pulses, 1);
  endtask

  initial begin
    int pulses;
    logic [15:0] ra;
    logic [15:0] rb;

    rst     = 1'b0;
    init_in = 1'b0;
    A       = 16'd0;
    B       = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset Result", {16'd0, Result}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic case with init_in held for two cycles
    run_op(16'd35, 16'd5, 2, 0, "35/5");
    // Boundary and directed cases
    run_op(16'd65535, 16'd1, 1, 0, "65535/1");
    run_op(16'd7, 16'd9, 1, 0, "7/9");
    run_op(16'd1000, 16'd7, 1, 0, "1000/7");
    run_op(16'd100, 16'd0, 1, 0, "100/0");
    // Level held through completion must not retrigger
    run_op(16'd40000, 16'd123, 30, 0, "held_level");
    // Operand changes and a fresh edge during CALC are ignored
    run_op(16'd35, 16'd5, 1, 3, "disturb");

    // Reset at cycle 8 of a division aborts it
    @(negedge clk);
    A       = 16'd5000;
    B       = 16'd3;
    init_in = 1'b1;
    @(posedge clk);
    #1;
    init_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort done", {31'd0, done}, 32'd0);
    check("abort Result", {16'd0, Result}, 32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort no_done", pulses, 0);
    run_op(16'd1000, 16'd7, 1, 0, "after_abort");

    // init_in already high at reset release counts as a rising edge
    @(negedge clk);
    rst     = 1'b0;
    init_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_op(16'd50000, 16'd3, 3, 0, "high_at_release");

    // Randomized operands
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom_range(0, 65535));
      if (i % 4 == 0) rb = 16'($urandom_range(0, 15));
      else            rb = 16'($urandom_range(0, 65535));
      run_op(ra, rb, int'($urandom_range(1, 3)), 0, $sformatf("rand%0d %0d/%0d", i, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_16.md
DIV_16 -- requirements
Module: div_16

Interface
REQ-001 Parameters: none; operand and result width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 init_in  input  1  start request; a rising edge (0 in previous cycle, 1 in current cycle) starts a division.
REQ-005 A  input  16  dividend, unsigned.
REQ-006 B  input  16  divisor, unsigned.
REQ-007 Result  output  16  quotient floor(A/B), registered.
REQ-008 done  output  1  one-cycle completion pulse, registered.

Function
REQ-009 The block SHALL implement an unsigned restoring shift-subtract divider producing one quotient bit per clock.
REQ-010 The block SHALL register init_in each clock to detect its rising edge; a held-high init_in SHALL start only one division.
REQ-011 FSM states SHALL be IDLE, CALC, DONE.
REQ-012 IDLE: on a detected init_in rising edge, the block SHALL capture A and B, clear the 17-bit partial remainder, load the iteration counter with 16, and enter CALC.
REQ-013 CALC, each cycle: remainder = {remainder[15:0], dividend MSB}; dividend register shifts left by 1.
REQ-014 CALC, each cycle: if remainder >= divisor, remainder -= divisor and the shifted-in quotient bit = 1; otherwise the bit = 0.
REQ-015 CALC: after the 16th iteration the block SHALL enter DONE.
REQ-016 DONE: the block SHALL load Result with the quotient, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency: for a rising edge of init_in sampled at clock edge N, done and the new Result SHALL be visible after clock edge N+17.
REQ-018 Result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during CALC.
REQ-019 Start-request edges occurring in CALC or DONE SHALL be ignored; the edge detector SHALL keep tracking, so a level held through completion does not retrigger.
REQ-020 A and B changes after capture SHALL NOT affect the operation in progress.
REQ-021 Divide by zero (B=0): the block SHALL complete with normal latency and Result=16'hFFFF (natural result of the restoring algorithm).
REQ-022 A < B SHALL give Result=0; B=1 SHALL give Result=A.

Reset
REQ-023 While rst=0, the block SHALL asynchronously force: FSM to IDLE, Result=0, done=0, counter, dividend, divisor, remainder and the init_in edge register all 0.
REQ-024 Reset asserted mid-CALC SHALL abort the division with no done pulse; after reset release, only a new init_in rising edge starts an operation.
REQ-025 After release, init_in already high SHALL count as a rising edge, because the edge register resets to 0.

Verification
REQ-026 Reset, then A=35, B=5, init_in high for 2 cycles -> Result=7, done pulses once 17 cycles after the start edge, no second pulse.
REQ-027 A=65535, B=1 -> Result=65535; A=7, B=9 -> Result=0; A=1000, B=7 -> Result=142.
REQ-028 A=100, B=0 -> Result=16'hFFFF, done after 17 cycles.
REQ-029 Change A/B and pulse init_in during CALC -> the first result is unaffected (35/5 gives 7) and no extra operation starts.
REQ-030 Assert rst=0 at cycle 8 of a division -> done stays 0, Result=0; a new start then completes correctly.
